// File: rtl/ucca_cfg_loader.sv
// ucca_cfg_loader: boot-time configurator for the UCCA region monitors.
// After reset it reads the region count and each region's min/max bounds
// from the metadata block, validates them, and commits them all at once to
// the ucc_min/ucc_max buses. Once committed it locks the configuration and
// flags a violation on any later write into the metadata window.
// Ports:
//   clk, system_reset        clock, synchronous active-high reset
//   mem_req/mem_addr         metadata read request and byte address (out)
//   mem_ack/mem_rdata        read completion and data (in)
//   data_en/data_wr/data_addr CPU data bus, snooped for metadata writes
//   ucc_min_flat/max_flat    per-region bounds, region i at [16i+15:16i]
//   cfg_busy/cfg_valid       load in progress / config committed and locked
//   cfg_err_code             first error seen (0 none, 1..5)
//   reset                    violation, OR'd into the system master reset
module ucca_cfg_loader #(
  parameter int          N_REGIONS   = 3,
  parameter logic [15:0] META_MIN    = 16'h0140,
  parameter logic [15:0] META_MAX    = 16'h016A,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      system_reset,
  output logic                      mem_req,
  output logic [15:0]               mem_addr,
  input  logic                      mem_ack,
  input  logic [15:0]               mem_rdata,
  input  logic                      data_en,
  input  logic                      data_wr,
  input  logic [15:0]               data_addr,
  output logic [16*N_REGIONS-1:0]   ucc_min_flat,
  output logic [16*N_REGIONS-1:0]   ucc_max_flat,
  output logic                      cfg_busy,
  output logic                      cfg_valid,
  output logic [2:0]                cfg_err_code,
  output logic                      reset
);

  localparam int IW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_CNT = 3'd1;
  localparam logic [2:0] S_RD_MIN = 3'd2;
  localparam logic [2:0] S_RD_MAX = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;
  localparam logic [2:0] S_LOCKED = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  logic [2:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        cfg_busy_q, cfg_busy_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic [2:0]  err_code_q, err_code_d;
  logic        reset_q, reset_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N_REGIONS-1:0][15:0] min_sh_q, min_sh_d, max_sh_q, max_sh_d;
  logic [N_REGIONS-1:0][15:0] ucc_min_q, ucc_min_d, ucc_max_q, ucc_max_d;

  logic        meta_wr, err_hit;
  logic [2:0]  err_val;
  logic [IW-1:0] idx_nxt;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    cfg_busy_d  = cfg_busy_q;
    cfg_valid_d = cfg_valid_q;
    err_code_d  = err_code_q;
    reset_d     = reset_q;
    wait_cnt_d  = wait_cnt_q;
    count_d     = count_q;
    idx_d       = idx_q;
    min_sh_d    = min_sh_q;
    max_sh_d    = max_sh_q;
    ucc_min_d   = ucc_min_q;
    ucc_max_d   = ucc_max_q;
    err_hit     = 1'b0;
    err_val     = 3'd0;
    idx_nxt     = idx_q + 1'b1;
    meta_wr     = data_en & data_wr & (data_addr >= META_MIN) & (data_addr <= META_MAX);

    case (state_q)
      S_IDLE: begin
        state_d    = S_RD_CNT;
        mem_req_d  = 1'b1;
        mem_addr_d = META_MIN;
        wait_cnt_d = 8'd0;
        cfg_busy_d = 1'b1;
      end
      // Read states: while mem_req is high we wait for the ack; the cycle
      // with mem_req low is the mandatory gap before the next request.
      S_RD_CNT, S_RD_MIN, S_RD_MAX: begin
        if (mem_req_q) begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            case (state_q)
              S_RD_CNT: count_d          = mem_rdata;
              S_RD_MIN: min_sh_d[idx_q]  = mem_rdata;
              default:  max_sh_d[idx_q]  = mem_rdata;
            endcase
          end else if (wait_cnt_q == 8'(ACK_TIMEOUT - 1)) begin
            err_hit = 1'b1;
            err_val = 3'd4;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          case (state_q)
            S_RD_CNT: begin
              if (count_q == 16'd0) begin
                state_d = S_COMMIT;
              end else if (count_q > 16'(N_REGIONS)) begin
                err_hit = 1'b1;
                err_val = 3'd1;
              end else begin
                state_d    = S_RD_MIN;
                idx_d      = '0;
                mem_req_d  = 1'b1;
                mem_addr_d = META_MIN + 16'd2;
                wait_cnt_d = 8'd0;
              end
            end
            S_RD_MIN: begin
              state_d    = S_RD_MAX;
              mem_req_d  = 1'b1;
              mem_addr_d = META_MIN + 16'd4 + (16'(idx_q) << 2);
              wait_cnt_d = 8'd0;
            end
            default: state_d = S_CHECK;
          endcase
        end
      end
      S_CHECK: begin
        if (min_sh_q[idx_q] > max_sh_q[idx_q]) begin
          err_hit = 1'b1;
          err_val = 3'd2;
        end else if ((idx_q != '0) && (min_sh_q[idx_q] <= max_sh_q[idx_q - 1'b1])) begin
          err_hit = 1'b1;
          err_val = 3'd3;
        end else if (16'(idx_q) + 16'd1 == count_q) begin
          state_d = S_COMMIT;
        end else begin
          state_d    = S_RD_MIN;
          idx_d      = idx_nxt;
          mem_req_d  = 1'b1;
          mem_addr_d = META_MIN + 16'd2 + (16'(idx_nxt) << 2);
          wait_cnt_d = 8'd0;
        end
      end
      S_COMMIT: begin
        for (int i = 0; i < N_REGIONS; i++) begin
          ucc_min_d[i] = (16'(i) < count_q) ? min_sh_q[i] : 16'hFFFF;
          ucc_max_d[i] = (16'(i) < count_q) ? max_sh_q[i] : 16'h0000;
        end
        state_d     = S_LOCKED;
        cfg_busy_d  = 1'b0;
        cfg_valid_d = 1'b1;
      end
      default: ;
    endcase

    // Metadata tamper wins over anything else decided this cycle.
    if (meta_wr && (state_q inside {S_RD_CNT, S_RD_MIN, S_RD_MAX, S_CHECK, S_COMMIT, S_LOCKED})) begin
      err_hit = 1'b1;
      err_val = 3'd5;
    end

    if (err_hit) begin
      state_d     = S_ERROR;
      mem_req_d   = 1'b0;
      cfg_busy_d  = 1'b0;
      cfg_valid_d = 1'b0;
      reset_d     = 1'b1;
      ucc_min_d   = '1;
      ucc_max_d   = '0;
      if (err_code_q == 3'd0) err_code_d = err_val;
    end
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= META_MIN;
      cfg_busy_q  <= 1'b0;
      cfg_valid_q <= 1'b0;
      err_code_q  <= 3'd0;
      reset_q     <= 1'b0;
      wait_cnt_q  <= 8'd0;
      count_q     <= 16'd0;
      idx_q       <= '0;
      min_sh_q    <= '1;
      max_sh_q    <= '0;
      ucc_min_q   <= '1;
      ucc_max_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      cfg_busy_q  <= cfg_busy_d;
      cfg_valid_q <= cfg_valid_d;
      err_code_q  <= err_code_d;
      reset_q     <= reset_d;
      wait_cnt_q  <= wait_cnt_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      min_sh_q    <= min_sh_d;
      max_sh_q    <= max_sh_d;
      ucc_min_q   <= ucc_min_d;
      ucc_max_q   <= ucc_max_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign cfg_busy     = cfg_busy_q;
  assign cfg_valid    = cfg_valid_q;
  assign cfg_err_code = err_code_q;
  assign reset        = reset_q;
  assign ucc_min_flat = ucc_min_q;
  assign ucc_max_flat = ucc_max_q;

endmodule

// File: tb/tb_ucca_cfg_loader.sv
module tb_ucca_cfg_loader;

  logic        clk = 1'b0;
  logic        system_reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        data_en, data_wr;
  logic [15:0] data_addr;
  logic [47:0] ucc_min_flat, ucc_max_flat;
  logic        cfg_busy, cfg_valid, reset;
  logic [2:0]  cfg_err_code;

  int checks = 0;
  int errors = 0;

  logic [15:0] meta [0:31];
  logic [15:0] hold_addr = 16'hFFFF;
  logic        req_prev = 1'b0;
  logic [15:0] addr_log [$];
  logic [15:0] off;

  ucca_cfg_loader dut (
    .clk(clk), .system_reset(system_reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr),
    .ucc_min_flat(ucc_min_flat), .ucc_max_flat(ucc_max_flat),
    .cfg_busy(cfg_busy), .cfg_valid(cfg_valid), .cfg_err_code(cfg_err_code), .reset(reset)
  );

  always #5 clk = ~clk;

  // Metadata memory: acks one cycle after a request is seen, unless the
  // request targets hold_addr. Logs the address of every new request.
  always @(negedge clk) begin
    if (mem_req && mem_addr != hold_addr) begin
      off       = mem_addr - 16'h0140;
      mem_ack   = 1'b1;
      mem_rdata = meta[off[5:1]];
    end else begin
      mem_ack   = 1'b0;
    end
    if (mem_req && !req_prev) addr_log.push_back(mem_addr);
    req_prev = mem_req;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_meta(input logic [15:0] c, m0, x0, m1, x1);
    for (int i = 0; i < 32; i++) meta[i] = 16'h0000;
    meta[0] = c; meta[1] = m0; meta[2] = x0; meta[3] = m1; meta[4] = x1;
  endtask

  task automatic restart();
    system_reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_clears_reset", reset, 0);
    addr_log.delete();
    system_reset = 1'b0;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (!(cfg_valid || reset) && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  localparam logic [47:0] DIS_MIN = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] DIS_MAX = 48'h0;

  initial begin
    int n;
    logic prev_busy;
    system_reset = 1'b1;
    data_en = 1'b0; data_wr = 1'b0; data_addr = 16'h0000;
    set_meta(16'd2, 16'hE000, 16'hE0FE, 16'hE100, 16'hE1FE);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 16'h0140);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_valid", cfg_valid, 0);
    chk("rst_code", cfg_err_code, 0);
    chk("rst_reset", reset, 0);
    chk("rst_min", ucc_min_flat, DIS_MIN);
    chk("rst_max", ucc_max_flat, DIS_MAX);
    addr_log.delete();
    system_reset = 1'b0;

    // One IDLE cycle, then count request
    @(negedge clk);
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 16'h0140);
    chk("first_busy", cfg_busy, 1);

    // Normal two-region load
    n = 0;
    prev_busy = cfg_busy;
    while (!cfg_valid && !reset && n < 400) begin
      prev_busy = cfg_busy;
      @(negedge clk);
      n++;
    end
    chk("load_in_time", n < 400, 1);
    chk("busy_before_valid", prev_busy, 1);
    chk("busy_with_valid", cfg_busy, 0);
    chk("ok_valid", cfg_valid, 1);
    chk("ok_code", cfg_err_code, 0);
    chk("ok_reset", reset, 0);
    chk("ok_min", ucc_min_flat, 48'hFFFF_E100_E000);
    chk("ok_max", ucc_max_flat, 48'h0000_E1FE_E0FE);
    chk("ok_nreq", addr_log.size(), 5);
    if (addr_log.size() == 5) begin
      chk("ok_a0", addr_log[0], 16'h0140);
      chk("ok_a1", addr_log[1], 16'h0142);
      chk("ok_a2", addr_log[2], 16'h0144);
      chk("ok_a3", addr_log[3], 16'h0146);
      chk("ok_a4", addr_log[4], 16'h0148);
    end

    // LOCKED: write outside window, read inside window, then real tamper
    data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h016C;
    @(negedge clk);
    data_en = 1'b0; data_wr = 1'b0;
    @(negedge clk);
    chk("wr16c_reset", reset, 0);
    chk("wr16c_valid", cfg_valid, 1);
    data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h0150;
    @(negedge clk);
    data_en = 1'b0;
    @(negedge clk);
    chk("rd150_reset", reset, 0);
    chk("rd150_min", ucc_min_flat, 48'hFFFF_E100_E000);
    data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0150;
    @(negedge clk);
    data_en = 1'b0; data_wr = 1'b0;
    chk("wr150_reset", reset, 1);
    chk("wr150_code", cfg_err_code, 5);
    chk("wr150_valid", cfg_valid, 0);
    chk("wr150_min", ucc_min_flat, DIS_MIN);
    chk("wr150_max", ucc_max_flat, DIS_MAX);
    repeat (3) @(negedge clk);
    chk("wr150_reset_held", reset, 1);

    // Overlap: R1 min == R0 max
    set_meta(16'd2, 16'hE000, 16'hE0FE, 16'hE0FE, 16'hE1FE);
    restart();
    wait_end(n);
    chk("ovl_code", cfg_err_code, 3);
    chk("ovl_reset", reset, 1);
    chk("ovl_valid", cfg_valid, 0);
    chk("ovl_busy", cfg_busy, 0);
    chk("ovl_req", mem_req, 0);
    chk("ovl_min", ucc_min_flat, DIS_MIN);
    chk("ovl_max", ucc_max_flat, DIS_MAX);
    repeat (4) @(negedge clk);
    chk("ovl_reset_held", reset, 1);

    // min > max
    set_meta(16'd1, 16'hE200, 16'hE100, 16'h0000, 16'h0000);
    restart();
    wait_end(n);
    chk("minmax_code", cfg_err_code, 2);

    // count too large: only the count read is issued
    set_meta(16'd4, 16'hE000, 16'hE0FE, 16'hE100, 16'hE1FE);
    restart();
    wait_end(n);
    chk("cnt_code", cfg_err_code, 1);
    chk("cnt_nreq", addr_log.size(), 1);

    // Ack withheld on the RD_MAX request
    set_meta(16'd1, 16'hE000, 16'hE0FE, 16'h0000, 16'h0000);
    hold_addr = 16'h0144;
    restart();
    n = 0;
    while (!(mem_req && mem_addr == 16'h0144) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_reach_rdmax", n < 100, 1);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_req_cycles", n, 16);
    chk("to_reset", reset, 1);
    chk("to_code", cfg_err_code, 4);
    hold_addr = 16'hFFFF;

    // system_reset in the middle of RD_MIN, then a full reload
    set_meta(16'd2, 16'hE000, 16'hE0FE, 16'hE100, 16'hE1FE);
    restart();
    n = 0;
    while (!(mem_req && mem_addr == 16'h0142) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_rdmin", n < 100, 1);
    system_reset = 1'b1;
    @(negedge clk);
    chk("abort_req", mem_req, 0);
    chk("abort_busy", cfg_busy, 0);
    chk("abort_min", ucc_min_flat, DIS_MIN);
    system_reset = 1'b0;
    wait_end(n);
    chk("reload_valid", cfg_valid, 1);
    chk("reload_code", cfg_err_code, 0);
    chk("reload_max", ucc_max_flat, 48'h0000_E1FE_E0FE);

    // Tamper coinciding with the count ack
    restart();
    @(negedge clk);
    chk("race_addr", mem_addr, 16'h0140);
    data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0150;
    @(negedge clk);
    data_en = 1'b0; data_wr = 1'b0;
    chk("race_code", cfg_err_code, 5);
    chk("race_reset", reset, 1);
    repeat (10) @(negedge clk);
    chk("race_no_load", cfg_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
